// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input port: register offsets and window decode.
package gpio_pkg;

  localparam logic [31:0] GPIO_LEVEL_OFS = 32'h0000_0000;
  localparam logic [31:0] GPIO_EDGE_OFS  = 32'h0000_0004;
  localparam logic [31:0] GPIO_MASK_OFS  = 32'h0000_0008;

  typedef enum logic [1:0] {
    RegLevel,
    RegEdge,
    RegMask,
    RegNone
  } gpio_reg_e;

  // Map a byte address onto one of the three window registers. The byte lane bits are
  // ignored, and the subtraction wraps so addresses below the base fall out as RegNone.
  function automatic gpio_reg_e gpio_decode(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] ofs;
    ofs = {addr[31:2], 2'b00} - {base[31:2], 2'b00};
    case (ofs)
      GPIO_LEVEL_OFS: gpio_decode = RegLevel;
      GPIO_EDGE_OFS:  gpio_decode = RegEdge;
      GPIO_MASK_OFS:  gpio_decode = RegMask;
      default:        gpio_decode = RegNone;
    endcase
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One input pin: 2-flop synchronizer, stability counter, debounced level and rise pulse.
module gpio_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Synchronizer chain for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive mismatching cycles; any return to the current level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise    = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
        // Pulse in the cycle the level is about to flip 0->1 so the edge flag lands with it.
        rise    = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounced level and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/gpio_input_port.sv
// Memory-mapped GPIO input port: debounced levels, clear-on-read rising-edge flags,
// interrupt mask, and a same-cycle read mux for the MEM stage.
module gpio_input_port
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pins,
  input  logic [31:0]      A,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             hit,
  output logic             irq
);

  gpio_reg_e        reg_sel;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             edge_clr;
  logic             unused_wdata;

  // Store data above WIDTH has no destination.
  assign unused_wdata = ^wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .pin  (pins[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  assign reg_sel  = gpio_decode(A, BASE_ADDR);
  assign hit      = (reg_sel != RegNone);
  assign edge_clr = rd_en && (reg_sel == RegEdge);

  // Edge flags clear on read, but a rise in the same cycle survives the clear.
  always_comb begin
    edge_d = edge_clr ? '0 : edge_q;
    edge_d = edge_d | rise;
  end

  // Mask takes store data only when the store hits the MASK offset.
  always_comb begin
    mask_d = mask_q;
    if (wr_en && (reg_sel == RegMask)) begin
      mask_d = wdata[WIDTH-1:0];
    end
  end

  // Edge and mask registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
      mask_q <= '0;
    end else begin
      edge_q <= edge_d;
      mask_q <= mask_d;
    end
  end

  // Read mux shows pre-update register contents, zero-extended.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      RegLevel: rdata[WIDTH-1:0] = level;
      RegEdge:  rdata[WIDTH-1:0] = edge_q;
      RegMask:  rdata[WIDTH-1:0] = mask_q;
      default:  rdata = '0;
    endcase
  end

  // Driven only from registers so address/strobe activity cannot glitch it.
  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_gpio_input_port.sv
// Directed bench for gpio_input_port with short debounce window.
module tb_gpio_input_port;

  localparam int unsigned W    = 8;
  localparam int unsigned DEB  = 4;
  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam logic [31:0] LVL  = BASE + 32'h0;
  localparam logic [31:0] EDG  = BASE + 32'h4;
  localparam logic [31:0] MSK  = BASE + 32'h8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] pins;
  logic [31:0]  A;
  logic         rd_en;
  logic         wr_en;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         hit;
  logic         irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_input_port #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DEB),
    .BASE_ADDR      (BASE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pins (pins),
    .A    (A),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .wdata(wdata),
    .rdata(rdata),
    .hit  (hit),
    .irq  (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational look at a register with no clock edge while rd_en is high.
  task automatic peek(input logic [31:0] addr, output logic [31:0] data);
    A     = addr;
    rd_en = 1'b1;
    #1;
    data  = rdata;
    rd_en = 1'b0;
    A     = 32'h0;
    #1;
  endtask

  // Full load access, including its side effect at the next clock edge.
  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    A     = addr;
    rd_en = 1'b1;
    #1;
    data  = rdata;
    tick();
    rd_en = 1'b0;
    A     = 32'h0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    A     = addr;
    wr_en = 1'b1;
    wdata = data;
    tick();
    wr_en = 1'b0;
    A     = 32'h0;
    wdata = 32'h0;
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 1'b1;
    pins  = 8'hFF;
    A     = 32'h0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    wdata = 32'h0;
    #2 rst_n = 1'b0;
    repeat (3) tick();

    // Reset state with pins high
    peek(LVL, d); check_eq("rst_level", d, 32'h0);
    peek(EDG, d); check_eq("rst_edge", d, 32'h0);
    peek(MSK, d); check_eq("rst_mask", d, 32'h0);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    A = LVL; #1; check_eq("rst_hit", {31'h0, hit}, 32'h1); A = 32'h0;

    // Release: level appears exactly 2+DEB edges later
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    peek(LVL, d); check_eq("rel_level_early", d, 32'h0);
    tick();
    peek(LVL, d); check_eq("rel_level", d, 32'hFF);
    peek(EDG, d); check_eq("rel_edge", d, 32'hFF);
    check_eq("rel_irq_masked", {31'h0, irq}, 32'h0);
    rd(EDG, d);   check_eq("rel_edge_read", d, 32'hFF);
    peek(EDG, d); check_eq("rel_edge_cleared", d, 32'h0);

    // Falling edges set no flags
    pins = 8'h00;
    repeat (8) tick();
    peek(LVL, d); check_eq("fall_level", d, 32'h0);
    peek(EDG, d); check_eq("fall_edge", d, 32'h0);

    // Debounce: 3-cycle pulse rejected, held pulse accepted at edge 6
    pins = 8'h01;
    repeat (3) tick();
    pins = 8'h00;
    repeat (8) tick();
    peek(LVL, d); check_eq("short_pulse_level", d, 32'h0);
    peek(EDG, d); check_eq("short_pulse_edge", d, 32'h0);
    pins = 8'h01;
    repeat (5) tick();
    peek(LVL, d); check_eq("db_level_cyc5", d, 32'h0);
    tick();
    peek(LVL, d); check_eq("db_level_cyc6", d, 32'h01);
    peek(EDG, d); check_eq("db_edge_cyc6", d, 32'h01);

    // Clear-on-read with EDGE=0x05
    pins = 8'h05;
    repeat (8) tick();
    rd(EDG, d);   check_eq("cor_read", d, 32'h5);
    rd(EDG, d);   check_eq("cor_reread", d, 32'h0);

    // Rising edge on pin1 lands on the read cycle: set wins over clear
    pins = 8'h07;
    repeat (5) tick();
    rd(EDG, d);   check_eq("setwin_read_pre", d, 32'h0);
    rd(EDG, d);   check_eq("setwin_next_read", d, 32'h2);
    peek(EDG, d); check_eq("setwin_cleared", d, 32'h0);

    // Interrupt on masked pin2 rising edge
    pins = 8'h03;
    repeat (8) tick();
    wr(MSK, 32'h04);
    peek(MSK, d); check_eq("mask_written", d, 32'h04);
    check_eq("irq_idle", {31'h0, irq}, 32'h0);
    pins = 8'h07;
    repeat (5) tick();
    check_eq("irq_before_edge", {31'h0, irq}, 32'h0);
    tick();
    check_eq("irq_on_edge", {31'h0, irq}, 32'h1);
    peek(EDG, d); check_eq("irq_edge_bits", d, 32'h04);
    rd(EDG, d);   check_eq("irq_edge_read", d, 32'h04);
    check_eq("irq_after_clear", {31'h0, irq}, 32'h0);

    // MASK=0 suppresses irq with EDGE nonzero; re-enabling raises it after the write edge
    wr(MSK, 32'h0);
    pins = 8'h03;
    repeat (8) tick();
    pins = 8'h07;
    repeat (8) tick();
    peek(EDG, d); check_eq("nomask_edge", d, 32'h04);
    check_eq("nomask_irq", {31'h0, irq}, 32'h0);
    A = MSK; wr_en = 1'b1; wdata = 32'h04; #1;
    check_eq("mask_wr_irq_before", {31'h0, irq}, 32'h0);
    tick();
    wr_en = 1'b0; A = 32'h0; wdata = 32'h0;
    check_eq("mask_wr_irq_after", {31'h0, irq}, 32'h1);

    // Decode outside the window
    A = BASE + 32'hC; rd_en = 1'b1; #1;
    check_eq("dec_above_hit", {31'h0, hit}, 32'h0);
    check_eq("dec_above_rdata", rdata, 32'h0);
    tick(); rd_en = 1'b0;
    A = BASE - 32'h4; rd_en = 1'b1; #1;
    check_eq("dec_below_hit", {31'h0, hit}, 32'h0);
    check_eq("dec_below_rdata", rdata, 32'h0);
    tick(); rd_en = 1'b0; A = 32'h0;
    peek(EDG, d); check_eq("dec_edge_kept", d, 32'h04);
    A = BASE + 32'h9; rd_en = 1'b1; #1;
    check_eq("dec_bytelane_hit", {31'h0, hit}, 32'h1);
    check_eq("dec_bytelane_mask", rdata, 32'h04);
    rd_en = 1'b0; A = 32'h0; #1;

    // Simultaneous read and write of MASK: read returns pre-write value
    A = MSK; rd_en = 1'b1; wr_en = 1'b1; wdata = 32'hFFFF_FFAA; #1;
    check_eq("rdwr_pre_value", rdata, 32'h04);
    tick();
    rd_en = 1'b0; wr_en = 1'b0; A = 32'h0; wdata = 32'h0;
    peek(MSK, d); check_eq("rdwr_post_value", d, 32'hAA);
    check_eq("rdwr_irq", {31'h0, irq}, 32'h0);

    // Writes to read-only registers are ignored
    wr(LVL, 32'h0);
    peek(LVL, d); check_eq("ro_level", d, 32'h07);
    wr(EDG, 32'h0);
    peek(EDG, d); check_eq("ro_edge", d, 32'h04);

    // Async reset two cycles into a mismatch
    pins = 8'h0F;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check_eq("async_irq", {31'h0, irq}, 32'h0);
    peek(LVL, d); check_eq("async_level", d, 32'h0);
    peek(EDG, d); check_eq("async_edge", d, 32'h0);
    peek(MSK, d); check_eq("async_mask", d, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    peek(LVL, d); check_eq("async_level_early", d, 32'h0);
    tick();
    peek(LVL, d); check_eq("async_level_full", d, 32'h0F);
    peek(EDG, d); check_eq("async_edge_full", d, 32'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_input_port.md
# gpio_input_port

Memory-mapped GPIO input responder: the read-side counterpart of the GPIO output driven by the memory stage. It synchronizes and debounces external switch/button pins, latches rising edges, and answers load accesses from the MEM stage with same-cycle read data so the existing result mux selects it exactly like memory read data. It also raises a level interrupt when any unmasked edge is pending.

## Interface
- WIDTH, 8: number of input pins; 1..32.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a new pin level; >= 2.
- BASE_ADDR, 32'h0000_0400: word-aligned base of the 3-word register window.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- pins  input  WIDTH  raw asynchronous external inputs.
- A  input  32  byte address from the execute stage.
- rd_en  input  1  load access this cycle.
- wr_en  input  1  store access this cycle.
- wdata  input  32  store data.
- rdata  output  32  read data, combinational, zero-extended above WIDTH.
- hit  output  1  A decodes to this window (either access type).
- irq  output  1  any pending edge with mask bit set.

## Operation
- Register map (offsets from BASE_ADDR): 0x0 LEVEL (RO, debounced level), 0x4 EDGE (RO, rising-edge flags, clear-on-read), 0x8 MASK (RW, interrupt enables). A[1:0] ignored; any other address: hit=0, rdata=0, no side effects.
- Per bit: 2-flop synchronizer -> debouncer -> edge detector.
- Debouncer per bit i: if sync[i]==level[i], cnt<=0; else if cnt==DEBOUNCE_CYCLES-1, level[i]<=sync[i], cnt<=0; else cnt<=cnt+1. Any glitch back to level restarts the count. cnt width $clog2(DEBOUNCE_CYCLES).
- Edge: when level[i] goes 0->1, edge[i]<=1. Falling transitions set nothing.
- EDGE read (rd_en & hit & offset 0x4): rdata shows pre-clear value; at the clock edge, edge bits clear, except bits with a new rising edge that same cycle, which stay set (set wins).
- MASK write (wr_en & hit & offset 0x8): mask<=wdata[WIDTH-1:0]. Writes to LEVEL/EDGE ignored. rd_en and wr_en both high: the write is performed, and the read returns the pre-write value.
- irq = |(edge & mask), combinational from registers; no glitches from A/rd_en.

## Timing
- Reset (async assert, sync release by system): sync flops, level, cnt, edge, mask = 0; rdata=0 when not hit; irq=0.
- Read latency 0: rdata valid in the cycle rd_en/A are presented; side effects take effect at the following clock edge.
- Pin-to-LEVEL latency: 2 synchronizer edges + DEBOUNCE_CYCLES edges of stable mismatch; EDGE bit and irq follow the LEVEL update in the same cycle.
- Reset mid-debounce discards partial counts; a pin already high at reset release produces a rising edge once debounced.
- MASK write affects irq in the cycle after the write edge.

## Structure
- Shared package gpio_pkg: offsets GPIO_LEVEL_OFS=0x0, GPIO_EDGE_OFS=0x4, GPIO_MASK_OFS=0x8, and a gpio_reg_e enum for the decoded register.
- Sub-module gpio_debounce_bit (synchronizer + counter + level + rise pulse), instantiated WIDTH times by generate; top holds decode, edge/mask registers, read mux.

## Test plan
- Reset: hold rst_n=0 with pins=8'hFF, rd LEVEL/EDGE/MASK -> all 0, irq=0; release -> LEVEL=8'hFF exactly 2+DEBOUNCE_CYCLES edges later, EDGE=8'hFF.
- Debounce (DEBOUNCE_CYCLES=4): pin0 high 3 cycles then low -> LEVEL stays 0; held 6 cycles -> LEVEL=8'h01 at cycle 6, EDGE=8'h01.
- Clear-on-read: EDGE=8'h05, read -> rdata=32'h5, next read -> 0; repeat with pin1 rising edge landing on the read cycle -> next read 32'h2.
- Interrupt: write MASK=8'h04, raise pin2 -> irq=1 when EDGE[2] sets; read EDGE -> irq=0 next cycle; MASK=0 suppresses irq with EDGE nonzero.
- Decode: rd at BASE_ADDR+0xC and BASE_ADDR-4 -> hit=0, rdata=0, EDGE unchanged; rd at BASE_ADDR+0x9 -> MASK contents.
- Async reset mid-count: assert rst_n during a 2-cycle-old mismatch -> all state 0 immediately, no LEVEL change after release until a full new count.
